// File: rtl/ram_loader.sv
// ram_loader: streams a byte sequence into consecutive RAM locations, then
// reads the region back and compares the readback sum against the sum of the
// accepted bytes. While active it owns the RAM bus and holds the CPU off.
module ram_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_write,
  output logic              ram_read,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_out,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  // Byte counter is one bit wider than the address so a full-space load fits.
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t            state_r,    state_s;
  logic [ADDR_W-1:0] base_r,     base_s;
  logic [CNT_W-1:0]  len_r,      len_s;
  logic [CNT_W-1:0]  count_r,    count_s;
  logic [DATA_W-1:0] checksum_r, checksum_s;
  logic [DATA_W-1:0] vsum_r,     vsum_s;
  logic              error_r,    error_s;
  logic              wr_r,       wr_s;
  logic              rd_r,       rd_s;
  logic [ADDR_W-1:0] addr_r,     addr_s;
  logic [DATA_W-1:0] data_r,     data_s;
  logic              busy_r;
  logic              done_r;
  logic              in_ready_s;

  // Upstream may only hand over bytes while loading.
  assign in_ready_s = (state_r == ST_LOAD);

  // Next-state, datapath and RAM-bus decisions; abort overrides everything.
  always_comb begin
    state_s    = state_r;
    base_s     = base_r;
    len_s      = len_r;
    count_s    = count_r;
    checksum_s = checksum_r;
    vsum_s     = vsum_r;
    error_s    = error_r;
    wr_s       = 1'b0;
    rd_s       = 1'b0;
    addr_s     = addr_r;
    data_s     = data_r;

    if (abort && (state_r != ST_IDLE)) begin
      // Partial checksum is intentionally kept for diagnosis.
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (abort) begin
            state_s = ST_IDLE;
          end else if (start) begin
            if (length == CNT_ZERO) begin
              state_s    = ST_DONE;
              checksum_s = DATA_ZERO;
              error_s    = 1'b0;
            end else if (length > MAX_LEN) begin
              state_s    = ST_DONE;
              checksum_s = DATA_ZERO;
              error_s    = 1'b1;
            end else begin
              state_s    = ST_LOAD;
              base_s     = base_addr;
              len_s      = length;
              count_s    = CNT_ZERO;
              checksum_s = DATA_ZERO;
              error_s    = 1'b0;
            end
          end else begin
            state_s = state_r;
          end
        end

        ST_LOAD: begin
          if (in_valid && in_ready_s) begin
            wr_s       = 1'b1;
            addr_s     = base_r + count_r[ADDR_W-1:0];
            data_s     = in_data;
            checksum_s = checksum_r + in_data;
            count_s    = count_r + CNT_ONE;
            if (count_r == (len_r - CNT_ONE)) begin
              state_s = ST_FLUSH;
            end else begin
              state_s = ST_LOAD;
            end
          end else begin
            state_s = ST_LOAD;
          end
        end

        ST_FLUSH: begin
          // Last write strobe is on the bus now; reads start next cycle.
          state_s = ST_VERIFY;
          count_s = CNT_ZERO;
          vsum_s  = DATA_ZERO;
          rd_s    = 1'b1;
          addr_s  = base_r;
        end

        ST_VERIFY: begin
          vsum_s = vsum_r + ram_out;
          if (count_r == (len_r - CNT_ONE)) begin
            state_s = ST_CHECK;
            rd_s    = 1'b0;
          end else begin
            state_s = ST_VERIFY;
            count_s = count_r + CNT_ONE;
            rd_s    = 1'b1;
            addr_s  = base_r + count_r[ADDR_W-1:0] + ADDR_ONE;
          end
        end

        ST_CHECK: begin
          state_s = ST_DONE;
          error_s = (vsum_r != checksum_r);
        end

        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered output flops with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      base_r     <= ADDR_ZERO;
      len_r      <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      checksum_r <= DATA_ZERO;
      vsum_r     <= DATA_ZERO;
      error_r    <= 1'b0;
      wr_r       <= 1'b0;
      rd_r       <= 1'b0;
      addr_r     <= ADDR_ZERO;
      data_r     <= DATA_ZERO;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      base_r     <= base_s;
      len_r      <= len_s;
      count_r    <= count_s;
      checksum_r <= checksum_s;
      vsum_r     <= vsum_s;
      error_r    <= error_s;
      wr_r       <= wr_s;
      rd_r       <= rd_s;
      addr_r     <= addr_s;
      data_r     <= data_s;
      busy_r     <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign in_ready    = in_ready_s;
  assign ram_write   = wr_r;
  assign ram_read    = rd_r;
  assign ram_address = addr_r;
  assign ram_data    = data_r;
  assign cpu_hold    = busy_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;
  assign checksum    = checksum_r;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a behavioural 256x8 RAM plus a reference model that
// predicts RAM contents, checksum, error flag and completion time from the
// loader's documented rules.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [8:0] length = 9'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       ram_write;
  logic       ram_read;
  logic [7:0] ram_address;
  logic [7:0] ram_data;
  logic [7:0] ram_out;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;

  logic [7:0] mem  [0:255];
  logic [7:0] stim [0:255];
  int         wr_count = 0;
  int         viol = 0;
  logic       corrupt_en = 1'b0;
  logic [7:0] corrupt_addr = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;

  ram_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_write(ram_write), .ram_read(ram_read), .ram_address(ram_address),
    .ram_data(ram_data), .ram_out(ram_out),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  // RAM read port, with an optional stuck-at-zero location for readback faults.
  assign ram_out = !ram_read ? 8'h00 :
                   ((corrupt_en && (ram_address == corrupt_addr)) ? 8'h00 : mem[ram_address]);

  // RAM write port and write counter.
  always @(posedge clk) begin
    if (ram_write) begin
      mem[ram_address] <= ram_data;
      wr_count <= wr_count + 1;
    end
  end

  // Bus-level rules that must hold on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if ((ram_write && ram_read) || (in_ready && !cpu_hold) ||
          (cpu_hold !== busy) || (done && cpu_hold))
        viol <= viol + 1;
    end
  end

  // One complete load: start, stream bytes, wait for done, compare with model.
  task automatic run_load(input logic [7:0] base, input int len, input int mode, input string name);
    int         n;
    int         idx;
    int         first_done;
    int         last_accept;
    int         bound;
    int         wr0;
    int         bad;
    int         exp_done;
    bit         legal;
    bit         v;
    logic [7:0] exp_sum;
    logic       exp_err;
    logic [7:0] a;
    legal   = (len != 0) && (len <= 256);
    exp_sum = 8'h00;
    exp_err = (len > 256);
    if (legal) begin
      for (int i = 0; i < len; i++) begin
        exp_sum = exp_sum + stim[i];
        a = base + 8'(i);
        if (corrupt_en && (a == corrupt_addr) && (stim[i] != 8'h00)) exp_err = 1'b1;
      end
    end
    wr0 = wr_count;
    @(negedge clk);
    start = 1'b1; base_addr = base; length = 9'(len); in_valid = 1'b0;
    n = 0; idx = 0; first_done = -1; last_accept = 0;
    bound = legal ? (2 * len + 3) * 4 + 20 : 10;
    while ((first_done < 0) && (n < bound)) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (legal && (n == 1)) begin
        n_checks++;
        if ({done, cpu_hold, in_ready} !== 3'b011)
          $display("FAIL %s first_cycle: done/hold/ready=%b required 011", name, {done, cpu_hold, in_ready});
        else n_pass++;
      end
      if (done) begin
        first_done = n;
        in_valid = 1'b0;
      end else if ((idx < len) && in_ready) begin
        if (mode == 0) v = 1'b1;
        else if (mode == 1) v = (n % 2 == 1);
        else v = 1'($urandom_range(0, 1));
        in_valid = v;
        in_data  = stim[idx];
        if (v) begin
          idx++;
          last_accept = n;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    exp_done = legal ? (last_accept + len + 3) : 1;
    n_checks++;
    if (first_done != exp_done)
      $display("FAIL %s done_cycle: got %0d required %0d", name, first_done, exp_done);
    else n_pass++;
    n_checks++;
    if (error !== exp_err)
      $display("FAIL %s error: got %b required %b", name, error, exp_err);
    else n_pass++;
    if (len <= 256) begin
      n_checks++;
      if (checksum !== exp_sum)
        $display("FAIL %s checksum: got %h required %h", name, checksum, exp_sum);
      else n_pass++;
    end
    n_checks++;
    if ({cpu_hold, busy} !== 2'b00)
      $display("FAIL %s hold_in_done: got %b required 00", name, {cpu_hold, busy});
    else n_pass++;
    n_checks++;
    if ((wr_count - wr0) != (legal ? len : 0))
      $display("FAIL %s write_count: got %0d required %0d", name, wr_count - wr0, legal ? len : 0);
    else n_pass++;
    if (legal) begin
      bad = 0;
      for (int i = 0; i < len; i++) begin
        a = base + 8'(i);
        if (mem[a] !== stim[i]) bad++;
      end
      n_checks++;
      if (bad != 0)
        $display("FAIL %s ram_contents: %0d wrong bytes required 0", name, bad);
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if ({in_ready, ram_write, ram_read, ram_address, ram_data, cpu_hold, busy, done, error, checksum} !== 31'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {in_ready, ram_write, ram_read, ram_address, ram_data, cpu_hold, busy, done, error, checksum});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, cpu_hold, done} !== 3'b000)
      $display("FAIL reset_idle: got %b required 000", {in_ready, cpu_hold, done});
    else n_pass++;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
    run_load(8'h10, 4, 0, "basic");
  endtask

  task automatic test_stall_wrap;
    stim[0] = 8'hFF; stim[1] = 8'h01; stim[2] = 8'h80; stim[3] = 8'h80;
    run_load(8'hFE, 4, 1, "stall_wrap");
  endtask

  task automatic test_corrupt;
    for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
    corrupt_en = 1'b1; corrupt_addr = 8'h11;
    run_load(8'h10, 4, 0, "corrupt");
    corrupt_en = 1'b0;
  endtask

  task automatic test_edge_lengths;
    run_load(8'h33, 0, 0, "len0");
    run_load(8'h10, 300, 0, "len300");
    for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
    run_load(8'h00, 256, 0, "len256");
  endtask

  task automatic test_abort;
    int         wr0;
    logic [7:0] exp_sum;
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom_range(1, 255));
    exp_sum = stim[0] + stim[1];
    wr0 = wr_count;
    @(negedge clk); start = 1'b1; base_addr = 8'h40; length = 9'd4;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = stim[0];
    @(negedge clk); in_data = stim[1];
    @(negedge clk); in_valid = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_checks++;
    if ({cpu_hold, busy, done, in_ready, ram_write, ram_read} !== 6'b0)
      $display("FAIL abort_outputs: got %b required 000000",
               {cpu_hold, busy, done, in_ready, ram_write, ram_read});
    else n_pass++;
    n_checks++;
    if (checksum !== exp_sum)
      $display("FAIL abort_partial_sum: got %h required %h", checksum, exp_sum);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ((wr_count - wr0) != 2 || mem[8'h40] !== stim[0] || mem[8'h41] !== stim[1])
      $display("FAIL abort_writes: got %0d writes required 2 with bytes %h %h", wr_count - wr0, stim[0], stim[1]);
    else n_pass++;
    start = 1'b1; abort = 1'b1; length = 9'd4;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_checks++;
    if ({cpu_hold, done, in_ready} !== 3'b000)
      $display("FAIL abort_beats_start: got %b required 000", {cpu_hold, done, in_ready});
    else n_pass++;
    run_load(8'h50, 0, 0, "len0_before_abort");
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_checks++;
    if (done !== 1'b0)
      $display("FAIL abort_from_done: done got %b required 0", done);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom_range(1, 255));
    @(negedge clk); start = 1'b1; base_addr = 8'h20; length = 9'd8;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = stim[0];
    @(negedge clk); in_data = stim[1];
    @(negedge clk); in_data = stim[2];
    @(negedge clk); in_valid = 1'b0;
    n_checks++;
    if ({ram_write, cpu_hold} !== 2'b11)
      $display("FAIL reset_mid_precond: write/hold got %b required 11", {ram_write, cpu_hold});
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, ram_write, ram_read, ram_address, ram_data, cpu_hold, busy, done, error, checksum} !== 31'd0)
      $display("FAIL reset_mid_async: got %h required 0",
               {in_ready, ram_write, ram_read, ram_address, ram_data, cpu_hold, busy, done, error, checksum});
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, cpu_hold, done, ram_write, ram_read} !== 5'b0)
      $display("FAIL reset_mid_idle: got %b required 00000", {in_ready, cpu_hold, done, ram_write, ram_read});
    else n_pass++;
  endtask

  task automatic test_random;
    int         len;
    logic [7:0] base;
    for (int t = 0; t < 6; t++) begin
      base = 8'($urandom_range(0, 255));
      len  = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) stim[i] = 8'($urandom);
      run_load(base, len, t % 3, "random");
    end
  endtask

  task automatic test_invariants;
    n_checks++;
    if (viol != 0)
      $display("FAIL bus_invariants: got %0d violating cycles required 0", viol);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall_wrap;
    test_corrupt;
    test_edge_lengths;
    test_abort;
    test_reset_mid;
    test_random;
    test_invariants;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
# ram_loader

Program loader that sits directly upstream of the 256×8 RAM. It accepts a byte stream over a valid/ready handshake and writes the bytes into consecutive RAM locations starting at a base address. It then reads the loaded region back and checks it against a mod-256 checksum. While it runs, it owns the RAM write/read/address/data bus and holds the CPU off through `cpu_hold`.

## Interface
- `ADDR_W`, default 8: RAM address width; the address space is 2^ADDR_W bytes.
- `DATA_W`, default 8: RAM data width.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: load request; sampled only in IDLE or DONE.
- `abort` input 1: cancels any operation in progress.
- `base_addr` input ADDR_W: first RAM address; sampled on the cycle `start` is accepted.
- `length` input ADDR_W+1: byte count, 0..256; sampled with `start`.
- `in_valid` input 1: upstream byte valid.
- `in_data` input DATA_W: upstream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `ram_write` output 1: RAM write strobe.
- `ram_read` output 1: RAM read enable.
- `ram_address` output ADDR_W: RAM address.
- `ram_data` output DATA_W: RAM write data.
- `ram_out` input DATA_W: RAM read data; combinational from `ram_address` while `ram_read` is high.
- `cpu_hold` output 1: high whenever the state is not IDLE or DONE.
- `busy` output 1: same as `cpu_hold`.
- `done` output 1: level, high in DONE.
- `error` output 1: checksum mismatch or illegal length; valid while `done` is high.
- `checksum` output DATA_W: mod-256 sum of the accepted bytes.

## Operation
- States: IDLE, LOAD, FLUSH, VERIFY, CHECK, DONE.
- Reset values: state=IDLE. All outputs are 0.
- All RAM-bus outputs are registered.
- IDLE/DONE + `start`:
  - `length`=0: go to DONE; `checksum`=0, `error`=0.
  - `length`>256: go to DONE with `error`=1.
  - Otherwise: latch `base_addr` and `length`, clear `count` and `checksum`, clear `error`, go to LOAD.
- LOAD: `in_ready`=1, decoded combinationally from state.
  - On `in_valid`&&`in_ready`, the next cycle registers `ram_write`=1, `ram_address`=(base+count) mod 2^ADDR_W, `ram_data`=`in_data`.
  - In the same cycle as the accept, `checksum`+=`in_data` (mod 256) and `count`++.
  - When the last byte (`count`=length−1) is accepted, go to FLUSH.
  - No accept means `ram_write`=0 on the next cycle.
- FLUSH: one cycle. The final write strobe is on the bus; `in_ready`=0. Go to VERIFY with `count`=0 and the verify sum=0.
- VERIFY: `ram_read`=1, `ram_address`=(base+count) mod 2^ADDR_W.
  - Each cycle, the verify sum accumulates `ram_out` at the current address.
  - After `length` reads, go to CHECK.
- CHECK: `ram_read`=0. Set `error`=(verify sum ≠ `checksum`). Go to DONE.
- DONE: `done`=1 and `cpu_hold`=0 until the next `start` is accepted. A new `start` in DONE clears `done` on the next cycle.
- Address wrap: base+count wraps modulo 256. With base=0xF0 and length=32, bytes go to 0xF0..0xFF and then 0x00..0x0F.
- `abort` in any state except IDLE: on the next edge, go to IDLE. `ram_write`, `ram_read`, `in_ready`, `busy` and `cpu_hold` all drop to 0; `checksum` keeps the partial sum; `done`=0.
- `abort` and `start` in the same cycle: `abort` wins and the state stays IDLE.
- Reset mid-operation: all outputs are 0 immediately, asynchronously. RAM contents already written are unaffected by the loader.

## Timing
- `start` accepted at edge 0; LOAD from cycle 1, with `in_ready`=1 during cycle 1.
- Byte accepted in cycle k: RAM write strobe in cycle k+1; the RAM captures it at the end of cycle k+1.
- Throughput is 1 byte per cycle with `in_valid` held high.
- Total for N bytes with no stalls: 1 (start) + N (LOAD) + 1 (FLUSH) + N (VERIFY) + 1 (CHECK) = 2N+3 cycles to `done`=1.
- `in_ready` never rises outside LOAD. `ram_write` and `ram_read` are never high in the same cycle.

## Test plan
- Reset: assert `rst` mid-LOAD → all outputs 0 in the same cycle; state is IDLE after release.
- Basic load: base=0x10, length=4, bytes 0x01,0x02,0x03,0x04 with `in_valid` held high → RAM[0x10..0x13] hold those bytes; `checksum`=0x0A; `done`=1 and `error`=0 after 11 cycles.
- Stall plus wrap: base=0xFE, length=4, `in_valid` toggled 1,0,1,0,… with bytes 0xFF,0x01,0x80,0x80 → writes land at 0xFE,0xFF,0x00,0x01; `checksum`=0x00; `error`=0.
- Corrupted readback: bench forces `ram_out` to 0x00 at address 0x11 during VERIFY in the basic case → `error`=1, `done`=1.
- Edge lengths: `length`=0 → `done` the next cycle with `checksum`=0. `length`=300 → `done`=1 with `error`=1 and no RAM writes. `length`=256 at base=0x00 → all 256 locations written.
- Abort: `abort` after the 2nd accepted byte of a 4-byte load → IDLE next cycle; only 2 RAM writes occur; `done`=0 and `cpu_hold`=0.
